// File: rtl/pipe_pulse_collector.sv
// pipe_pulse_collector
//
// Collects the single-cycle pulses leaving the last pulse-generator stage
// and groups them into fixed-length observation windows. A window opens on
// a pulse, counts every pulse seen during WINDOW cycles (including the
// opening cycle), and then holds one report on a valid/ready interface
// until the consumer takes it.
//
// Parameters
//   WINDOW  window length in cycles, including the opening cycle (>= 1)
//   CNT_W   width of the saturating pulse count
//   TS_W    timestamp width (only used when the timestamp feature is built)
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   pipe_in        pulse stream from the upstream stage
//   out_valid      report available
//   out_ready      consumer accepts the report
//   out_count      pulses counted in the window (saturating)
//   out_overflow   count saturated during the window
//   out_lost       pulses were discarded while the previous report was pending
//   out_timestamp  free-running time of the opening pulse (timestamp build only)
//   busy           high whenever the collector is not idle
//
// Optional feature
//   Define PIPE_PULSE_COLLECTOR_TIMESTAMP_EN to add a TS_W-bit free-running
//   counter and the out_timestamp port.

module pipe_pulse_collector #(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 8,
   parameter int TS_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pipe_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow,
   output logic             out_lost,
`ifdef PIPE_PULSE_COLLECTOR_TIMESTAMP_EN
   output logic [TS_W-1:0]  out_timestamp,
`endif
   output logic             busy
);

   localparam int               WIN_W    = $clog2(WINDOW) + 1;
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      REPORT
   } state_t;

   state_t           state, state_next;
   logic [WIN_W-1:0] win_cnt, win_cnt_next;
   logic [CNT_W-1:0] count, count_next;
   logic             overflow, overflow_next;
   logic             lost, lost_next;
   logic             load_report;

   // Next-state logic. The window down-counter is loaded with WINDOW-1 in
   // the opening cycle, so COLLECT covers the remaining WINDOW-1 cycles and
   // the report is loaded on the edge that ends the last window cycle.
   // The lost flag is handed to the report when the report is loaded and
   // restarts there, so pulses dropped during a pending report (including
   // its handshake cycle) show up in the following report.
   always_comb begin
      state_next    = state;
      win_cnt_next  = win_cnt;
      count_next    = count;
      overflow_next = overflow;
      lost_next     = lost;
      load_report   = 1'b0;

      case (state)
         IDLE: begin
            if (pipe_in) begin
               count_next    = CNT_W'(1);
               overflow_next = 1'b0;
               win_cnt_next  = WIN_LOAD;
               if (WINDOW == 1) begin
                  state_next  = REPORT;
                  load_report = 1'b1;
                  lost_next   = 1'b0;
               end else begin
                  state_next = COLLECT;
               end
            end
         end

         COLLECT: begin
            if (pipe_in) begin
               if (count == CNT_MAX) begin
                  overflow_next = 1'b1;
               end else begin
                  count_next = count + CNT_W'(1);
               end
            end
            if (win_cnt == WIN_W'(1)) begin
               state_next  = REPORT;
               load_report = 1'b1;
               lost_next   = 1'b0;
            end else begin
               win_cnt_next = win_cnt - WIN_W'(1);
            end
         end

         REPORT: begin
            if (pipe_in) begin
               lost_next = 1'b1;
            end
            if (out_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, window bookkeeping and report registers. The report registers
   // only change when a new report is loaded, which keeps them stable for
   // the whole time out_valid is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         win_cnt      <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         lost         <= 1'b0;
         out_count    <= '0;
         out_overflow <= 1'b0;
         out_lost     <= 1'b0;
      end else begin
         state    <= state_next;
         win_cnt  <= win_cnt_next;
         count    <= count_next;
         overflow <= overflow_next;
         lost     <= lost_next;
         if (load_report) begin
            out_count    <= count_next;
            out_overflow <= overflow_next;
            out_lost     <= lost;
         end
      end
   end

`ifdef PIPE_PULSE_COLLECTOR_TIMESTAMP_EN
   logic [TS_W-1:0] ts, open_ts;

   // Free-running time base. The opening time is latched in the opening
   // cycle; with a one-cycle window the report is loaded in that same
   // cycle, so the live counter value is used directly.
   always_ff @(posedge clk) begin
      if (reset) begin
         ts            <= '0;
         open_ts       <= '0;
         out_timestamp <= '0;
      end else begin
         ts <= ts + TS_W'(1);
         if (state == IDLE && pipe_in) begin
            open_ts <= ts;
         end
         if (load_report) begin
            out_timestamp <= (state == IDLE) ? ts : open_ts;
         end
      end
   end
`endif

   assign out_valid = (state == REPORT);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pipe_pulse_collector.sv
// tb_pipe_pulse_collector
//
// Directed bench for pipe_pulse_collector. Three instances share clock and
// reset: u8 (WINDOW=8, CNT_W=3, TS_W=4), u4 (WINDOW=4) and u1 (WINDOW=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_pipe_pulse_collector;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic       pipe8 = 1'b0, ready8 = 1'b1;
   logic       valid8, ovf8, lost8, busy8;
   logic [2:0] count8;

   logic       pipe4 = 1'b0, ready4 = 1'b1;
   logic       valid4, ovf4, lost4, busy4;
   logic [3:0] count4;

   logic       pipe1 = 1'b0, ready1 = 1'b1;
   logic       valid1, ovf1, lost1, busy1;
   logic [3:0] count1;

`ifdef PIPE_PULSE_COLLECTOR_TIMESTAMP_EN
   logic [3:0]  ts8;
   logic [15:0] ts4, ts1;
`endif

   int errors = 0;
   int checks = 0;

   // 10-unit clock period
   always #5 clk = ~clk;

   pipe_pulse_collector #(.WINDOW(8), .CNT_W(3), .TS_W(4)) u8 (
      .clk(clk), .reset(reset), .pipe_in(pipe8), .out_valid(valid8),
      .out_ready(ready8), .out_count(count8), .out_overflow(ovf8),
      .out_lost(lost8),
`ifdef PIPE_PULSE_COLLECTOR_TIMESTAMP_EN
      .out_timestamp(ts8),
`endif
      .busy(busy8)
   );

   pipe_pulse_collector #(.WINDOW(4), .CNT_W(4)) u4 (
      .clk(clk), .reset(reset), .pipe_in(pipe4), .out_valid(valid4),
      .out_ready(ready4), .out_count(count4), .out_overflow(ovf4),
      .out_lost(lost4),
`ifdef PIPE_PULSE_COLLECTOR_TIMESTAMP_EN
      .out_timestamp(ts4),
`endif
      .busy(busy4)
   );

   pipe_pulse_collector #(.WINDOW(1), .CNT_W(4)) u1 (
      .clk(clk), .reset(reset), .pipe_in(pipe1), .out_valid(valid1),
      .out_ready(ready1), .out_count(count1), .out_overflow(ovf1),
      .out_lost(lost1),
`ifdef PIPE_PULSE_COLLECTOR_TIMESTAMP_EN
      .out_timestamp(ts1),
`endif
      .busy(busy1)
   );

   // Advance one cycle and move just past the edge
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // All instances must come out of reset idle with a cleared report
   task automatic test_reset;
      reset = 1'b1;
      step();
      step();
      checks++;
      if ({valid8, busy8, count8, ovf8, lost8} !== 7'b0) begin
         errors++;
         $display("[TB] FAIL reset_u8: got %b expected 0000000", {valid8, busy8, count8, ovf8, lost8});
      end
      checks++;
      if ({valid4, busy4, count4, ovf4, lost4} !== 8'b0) begin
         errors++;
         $display("[TB] FAIL reset_u4: got %b expected 00000000", {valid4, busy4, count4, ovf4, lost4});
      end
      checks++;
      if ({valid1, busy1, count1, ovf1, lost1} !== 8'b0) begin
         errors++;
         $display("[TB] FAIL reset_u1: got %b expected 00000000", {valid1, busy1, count1, ovf1, lost1});
      end
      reset = 1'b0;
      step();
   endtask

   // One pulse: out_valid only in T+8, busy from T+1 through T+8
   task automatic test_single_pulse;
      logic exp_valid;
      ready8 = 1'b1;
      pipe8 = 1'b1;
      step();
      pipe8 = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         exp_valid = (i == 8);
         checks++;
         if (valid8 !== exp_valid) begin
            errors++;
            $display("[TB] FAIL single_valid[T+%0d]: got %b expected %b", i, valid8, exp_valid);
         end
         checks++;
         if (busy8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_busy[T+%0d]: got %b expected 1", i, busy8);
         end
         if (i < 8) step();
      end
      checks++;
      if ({count8, ovf8, lost8} !== {3'd1, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL single_report: got cnt=%0d ovf=%b lost=%b expected cnt=1 ovf=0 lost=0", count8, ovf8, lost8);
      end
      step();
      checks++;
      if ({valid8, busy8} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL single_after: got valid,busy=%b expected 00", {valid8, busy8});
      end
   endtask

   // Eight pulses into a 3-bit count saturate at 7; a later sparse window
   // must start clean
   task automatic test_overflow;
      logic [7:0] pat;
      pipe8 = 1'b1;
      repeat (8) step();
      pipe8 = 1'b0;
      checks++;
      if ({valid8, count8, ovf8} !== {1'b1, 3'd7, 1'b1}) begin
         errors++;
         $display("[TB] FAIL overflow_report: got v=%b cnt=%0d ovf=%b expected v=1 cnt=7 ovf=1", valid8, count8, ovf8);
      end
      step();
      pat = 8'b0010_0101;
      for (int i = 0; i < 8; i++) begin
         pipe8 = pat[i];
         step();
      end
      pipe8 = 1'b0;
      checks++;
      if ({valid8, count8, ovf8, lost8} !== {1'b1, 3'd3, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL sparse_report: got v=%b cnt=%0d ovf=%b lost=%b expected v=1 cnt=3 ovf=0 lost=0", valid8, count8, ovf8, lost8);
      end
      step();
   endtask

   // Report held by out_ready=0 with two dropped pulses; next report flags
   // them, the one after that does not
   task automatic test_lost;
      ready4 = 1'b0;
      pipe4 = 1'b1;
      step();
      pipe4 = 1'b0;
      repeat (3) step();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({valid4, count4, ovf4, lost4} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL lost_hold[%0d]: got v=%b cnt=%0d ovf=%b lost=%b expected v=1 cnt=1 ovf=0 lost=0", i, valid4, count4, ovf4, lost4);
         end
         pipe4 = (i == 1 || i == 3);
         step();
      end
      pipe4 = 1'b0;
      ready4 = 1'b1;
      checks++;
      if ({valid4, count4} !== {1'b1, 4'd1}) begin
         errors++;
         $display("[TB] FAIL lost_hs_cycle: got v=%b cnt=%0d expected v=1 cnt=1", valid4, count4);
      end
      step();
      checks++;
      if ({valid4, busy4} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL lost_after_hs: got valid,busy=%b expected 00", {valid4, busy4});
      end
      // pulse in H+1 opens the next window at once
      pipe4 = 1'b1;
      step();
      pipe4 = 1'b0;
      repeat (3) step();
      checks++;
      if ({valid4, count4, lost4} !== {1'b1, 4'd1, 1'b1}) begin
         errors++;
         $display("[TB] FAIL lost_next: got v=%b cnt=%0d lost=%b expected v=1 cnt=1 lost=1", valid4, count4, lost4);
      end
      step();
      pipe4 = 1'b1;
      step();
      pipe4 = 1'b0;
      repeat (3) step();
      checks++;
      if ({valid4, count4, lost4} !== {1'b1, 4'd1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL lost_cleared: got v=%b cnt=%0d lost=%b expected v=1 cnt=1 lost=0", valid4, count4, lost4);
      end
      step();
   endtask

   // One-cycle window: pulse at 5 reports at 6, pulse at 6 is lost,
   // pulse at 8 reports at 9 carrying the lost flag
   task automatic test_window_one;
      ready1 = 1'b1;
      pipe1 = 1'b1;
      step();
      checks++;
      if ({valid1, count1, lost1} !== {1'b1, 4'd1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL w1_first: got v=%b cnt=%0d lost=%b expected v=1 cnt=1 lost=0", valid1, count1, lost1);
      end
      step();
      pipe1 = 1'b0;
      checks++;
      if ({valid1, busy1} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL w1_idle: got valid,busy=%b expected 00", {valid1, busy1});
      end
      step();
      pipe1 = 1'b1;
      step();
      pipe1 = 1'b0;
      checks++;
      if ({valid1, count1, ovf1, lost1} !== {1'b1, 4'd1, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL w1_second: got v=%b cnt=%0d ovf=%b lost=%b expected v=1 cnt=1 ovf=0 lost=1", valid1, count1, ovf1, lost1);
      end
      step();
   endtask

   // Reset inside a window drops it; the next window starts from scratch
   task automatic test_reset_midwindow;
      logic bad;
      ready8 = 1'b1;
      pipe8 = 1'b1;
      step();
      step();
      pipe8 = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({valid8, busy8, count8, ovf8, lost8} !== 7'b0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: got %b expected 0000000", {valid8, busy8, count8, ovf8, lost8});
      end
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (valid8 !== 1'b0 || busy8 !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_no_report: got spurious activity=%b expected 0", bad);
      end
      pipe8 = 1'b1;
      step();
      pipe8 = 1'b0;
      repeat (7) step();
      checks++;
      if ({valid8, count8, ovf8} !== {1'b1, 3'd1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL midreset_fresh: got v=%b cnt=%0d ovf=%b expected v=1 cnt=1 ovf=0", valid8, count8, ovf8);
      end
      step();
   endtask

`ifdef PIPE_PULSE_COLLECTOR_TIMESTAMP_EN
   // Windows opened at cycles 20 and 40 after reset; 4-bit time wraps
   task automatic test_timestamp;
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (20) step();
      pipe8 = 1'b1;
      step();
      pipe8 = 1'b0;
      repeat (7) step();
      checks++;
      if ({valid8, ts8} !== {1'b1, 4'd4}) begin
         errors++;
         $display("[TB] FAIL ts_first: got v=%b ts=%0d expected v=1 ts=4", valid8, ts8);
      end
      step();
      repeat (11) step();
      pipe8 = 1'b1;
      step();
      pipe8 = 1'b0;
      repeat (7) step();
      checks++;
      if ({valid8, ts8} !== {1'b1, 4'd8}) begin
         errors++;
         $display("[TB] FAIL ts_second: got v=%b ts=%0d expected v=1 ts=8", valid8, ts8);
      end
      step();
   endtask
`endif

   // Run the scenarios in order and print the summary
   initial begin
      test_reset();
      test_single_pulse();
      test_overflow();
      test_lost();
      test_window_one();
      test_reset_midwindow();
`ifdef PIPE_PULSE_COLLECTOR_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
